ad7928_chan_avg: RTL and testbench

AD7928_CHAN_AVG -- requirements
Module: ad7928_chan_avg

---
 rtl/ad7928_chan_avg.sv | 127 ++++++++++++
 tb/tb_ad7928_chan_avg.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7928_chan_avg.sv
// ad7928_chan_avg: per-channel boxcar averager for a time-multiplexed ADC
// sample stream. Each of the 8 channels sums 2^LOG2_AVG samples. The
// truncated mean is then queued, tagged with its channel number, in a
// small result FIFO.
module ad7928_chan_avg #(
  parameter int DIN_WIDTH  = 8,
  parameter int LOG2_AVG   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] s_axis_tdata,
  input  logic [2:0]           s_axis_tuser,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [7:0]           ch_en,
  output logic [DIN_WIDTH-1:0] m_axis_tdata,
  output logic [2:0]           m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int AW = DIN_WIDTH + LOG2_AVG;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DIN_WIDTH + 3;

  logic [AW-1:0]        r_acc [8];
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW:0]          r_count;
  logic                 r_ovf;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr;
  logic [AW-1:0]        w_sum;
  logic [DIN_WIDTH-1:0] w_result;

  // The accumulator cannot overflow: 2^L samples of at most 2^D-1 fit in D+L bits.
  assign w_accept = s_axis_tvalid & ch_en[s_axis_tuser];
  assign w_sum    = r_acc[s_axis_tuser] + AW'(s_axis_tdata);
  assign w_result = DIN_WIDTH'(w_sum >> LOG2_AVG);
  assign w_push   = w_accept & w_last;

  generate
    if (LOG2_AVG > 0) begin : g_cnt
      logic [LOG2_AVG-1:0] r_cnt [8];

      assign w_last = &r_cnt[s_axis_tuser];

      // Per-channel sample count. It wraps to zero on the sample that completes a window.
      always_ff @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
          if (rst || !ch_en[i])
            r_cnt[i] <= '0;
          else if (w_accept && s_axis_tuser == 3'(i))
            r_cnt[i] <= r_cnt[i] + LOG2_AVG'(1);
        end
      end
    end else begin : g_no_cnt
      assign w_last = 1'b1;
    end
  endgenerate

  // Per-channel running sum. It is held at zero while the channel is
  // disabled, so any partial window is discarded.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 8; i++) begin
      if (rst || !ch_en[i])
        r_acc[i] <= '0;
      else if (w_accept && s_axis_tuser == 3'(i))
        r_acc[i] <= w_last ? '0 : w_sum;
    end
  end

  // When the FIFO is full, a push is accepted only if a pop frees a slot on the same edge.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && m_axis_tready;
  assign w_wr    = w_push && (!w_full || w_pop);

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage. It has no reset, because the outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= {s_axis_tuser, w_result};
  end

  // Sticky drop flag. A clear wins over a same-cycle drop.
  always_ff @(posedge CLK) begin
    if (rst || ovf_clr)
      r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop)
      r_ovf <= 1'b1;
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tvalid = !w_empty;
  assign {m_axis_tuser, m_axis_tdata} = w_empty ? '0 : r_mem[r_rd_ptr];
  assign ovf = r_ovf;

endmodule

// File: tb/tb_ad7928_chan_avg.sv
// Bench for ad7928_chan_avg with default parameters: directed scenarios plus
// a randomized run checked against a window/queue reference model.
module tb_ad7928_chan_avg;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic [2:0] s_axis_tuser = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] ch_en = 8'hFF;
  logic [7:0] m_axis_tdata;
  logic [2:0] m_axis_tuser;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  ad7928_chan_avg dut (
    .CLK(CLK), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .ch_en(ch_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Reference model: each channel's window is a running sum plus a sample
  // tally. Results go into a queue that holds up to 8 entries.
  int          wsum [8];
  int          wn   [8];
  logic [10:0] mq [$];
  logic        m_ovf = 1'b0;

  function automatic void model_edge();
    bit full_b, popped, drop;
    int res;
    if (rst) begin
      for (int n = 0; n < 8; n++) begin wsum[n] = 0; wn[n] = 0; end
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    full_b = (mq.size() == 8);
    popped = m_axis_tready && (mq.size() != 0);
    if (popped) void'(mq.pop_front());
    drop = 1'b0;
    for (int n = 0; n < 8; n++)
      if (!ch_en[n]) begin wsum[n] = 0; wn[n] = 0; end
    if (s_axis_tvalid && ch_en[s_axis_tuser]) begin
      wsum[s_axis_tuser] += int'(s_axis_tdata);
      wn[s_axis_tuser]   += 1;
      if (wn[s_axis_tuser] == 4) begin
        res = wsum[s_axis_tuser] / 4;
        wsum[s_axis_tuser] = 0;
        wn[s_axis_tuser]   = 0;
        if (full_b && !popped) drop = 1'b1;
        else mq.push_back({s_axis_tuser, 8'(res)});
      end
    end
    if (ovf_clr) m_ovf = 1'b0;
    else if (drop) m_ovf = 1'b1;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    s_axis_tvalid = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic send(input logic [2:0] ch, input logic [7:0] d);
    s_axis_tuser = ch;
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_en = 8'hFF;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(3'(i), 8'($urandom));
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata, ovf, s_axis_tready} !== 14'h0001) begin
        n_err++;
        $display("FAIL reset_outputs: got %h want %h",
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata, ovf, s_axis_tready}, 14'h0001);
      end
    end
    rst = 1'b0;
    cyc();
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_tvalid: got %b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_single_window();
    int d [4] = '{10, 20, 30, 41};
    logic [11:0] exp;
    for (int i = 0; i < 4; i++) begin
      send(3'd3, 8'(d[i]));
      exp = (i == 3) ? {1'b1, 3'd3, 8'd25} : 12'h000;
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== exp) begin
        n_err++;
        $display("FAIL single_window[%0d]: got %h want %h", i,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, exp);
      end
    end
    cyc();
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_window_one_beat: got tvalid %b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_interleave();
    int ch [8] = '{0, 7, 0, 7, 0, 7, 7, 0};
    int dd [8] = '{255, 1, 255, 1, 255, 1, 2, 255};
    logic [11:0] exp;
    for (int i = 0; i < 8; i++) begin
      send(3'(ch[i]), 8'(dd[i]));
      exp = (i == 6) ? {1'b1, 3'd7, 8'd1} : (i == 7) ? {1'b1, 3'd0, 8'd255} : 12'h000;
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== exp) begin
        n_err++;
        $display("FAIL interleave[%0d]: got %h want %h", i,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, exp);
      end
    end
    cyc();
  endtask

  task automatic test_enable();
    logic [11:0] exp;
    ch_en = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 8'($urandom));
      n_vec++;
      if (m_axis_tvalid !== 1'b0) begin
        n_err++;
        $display("FAIL disabled_ch_output: got tvalid %b want 0", m_axis_tvalid);
      end
    end
    ch_en = 8'hFF;
    send(3'd0, 8'd100);
    send(3'd0, 8'd100);
    ch_en = 8'hFE;
    cyc();
    ch_en = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 8'd8);
      exp = (i == 3) ? {1'b1, 3'd0, 8'd8} : 12'h000;
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== exp) begin
        n_err++;
        $display("FAIL enable_discard[%0d]: got %h want %h", i,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, exp);
      end
    end
    cyc();
  endtask

  task automatic test_overflow();
    int rch [9];
    int rd  [9];
    int sum;
    int c;
    int d;
    m_axis_tready = 1'b0;
    ch_en = 8'hFF;
    for (int w = 0; w < 9; w++) begin
      c = $urandom_range(0, 7);
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        d = $urandom_range(0, 255);
        sum += d;
        send(3'(c), 8'(d));
      end
      rch[w] = c;
      rd[w] = sum >> 2;
      n_vec++;
      if (ovf !== (w == 8)) begin
        n_err++;
        $display("FAIL ovf_after_window[%0d]: got %b want %b", w, ovf, (w == 8));
      end
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {1'b1, 3'(rch[0]), 8'(rd[0])}) begin
        n_err++;
        $display("FAIL full_head_hold[%0d]: got %h want %h", w,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, 3'(rch[0]), 8'(rd[0])});
      end
    end
    ovf_clr = 1'b1;
    cyc();
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: got %b want 0", ovf);
    end
    // A drop and a clear on the same edge: the clear wins.
    for (int k = 0; k < 3; k++) send(3'd6, 8'd77);
    ovf_clr = 1'b1;
    send(3'd6, 8'd77);
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr_priority: got %b want 0", ovf);
    end
    m_axis_tready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {1'b1, 3'(rch[w]), 8'(rd[w])}) begin
        n_err++;
        $display("FAIL drain_order[%0d]: got %h want %h", w,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, 3'(rch[w]), 8'(rd[w])});
      end
      cyc();
    end
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL drained_empty: got tvalid %b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_full_pop();
    int rch [9];
    int rd  [9];
    int sum;
    int c;
    int d;
    m_axis_tready = 1'b0;
    for (int w = 0; w < 9; w++) begin
      c = $urandom_range(0, 7);
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        d = $urandom_range(0, 255);
        sum += d;
        if (w == 8 && k == 3) m_axis_tready = 1'b1;
        send(3'(c), 8'(d));
      end
      rch[w] = c;
      rd[w] = sum >> 2;
    end
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop_ovf: got %b want 0", ovf);
    end
    for (int w = 1; w < 9; w++) begin
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {1'b1, 3'(rch[w]), 8'(rd[w])}) begin
        n_err++;
        $display("FAIL full_pop_order[%0d]: got %h want %h", w,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, 3'(rch[w]), 8'(rd[w])});
      end
      cyc();
    end
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop_empty: got tvalid %b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    m_axis_tready = 1'b0;
    for (int k = 0; k < 4; k++) send(3'd5, 8'd50);
    for (int k = 0; k < 3; k++) send(3'd2, 8'd100);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send(3'd2, 8'd4);
      n_vec++;
      if (m_axis_tvalid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_tvalid[%0d]: got %b want 0", k, m_axis_tvalid);
      end
    end
    rst = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(3'd2, 8'd4);
      exp = (i == 3) ? {1'b1, 3'd2, 8'd4} : 12'h000;
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== exp) begin
        n_err++;
        $display("FAIL reset_mid_window[%0d]: got %h want %h", i,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, exp);
      end
    end
    cyc();
  endtask

  task automatic test_random();
    logic [11:0] exp;
    for (int i = 0; i < 600; i++) begin
      if ((i % 80) < 40) m_axis_tready = ($urandom_range(0, 3) != 0);
      else m_axis_tready = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) ch_en = 8'($urandom) | 8'($urandom);
      ovf_clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 199) == 0);
      s_axis_tuser = 3'($urandom);
      s_axis_tdata = 8'($urandom);
      s_axis_tvalid = ($urandom_range(0, 9) < 8);
      cyc();
      rst = 1'b0;
      exp = (mq.size() != 0) ? {1'b1, mq[0]} : 12'h000;
      n_vec++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== exp) begin
        n_err++;
        $display("FAIL random_out[%0d]: got %h want %h", i,
                 {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, exp);
      end
      n_vec++;
      if ({ovf, s_axis_tready} !== {m_ovf, 1'b1}) begin
        n_err++;
        $display("FAIL random_flags[%0d]: got ovf,tready %b want %b", i,
                 {ovf, s_axis_tready}, {m_ovf, 1'b1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_interleave();
    test_enable();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
